// File: rtl/move_request_scheduler.sv
// move_request_scheduler
// Turns the PS/2 scan-code stream and the gravity tick into a single
// req/ack command stream for the gameplay datapath. Tracks one held key
// and auto-repeats it. At most one command is outstanding at a time.
//
// Handshake: move_req/move_cmd are held stable while move_req=1 until
// move_ack is sampled high. On that edge move_req and move_cmd drop to 0
// for one cycle. move_ack while move_req=0 has no effect.
module move_request_scheduler #(
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000,
  parameter int CNT_W         = 24
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       gravity_tick,
  input  logic       move_ack,
  output logic       move_req,
  output logic [2:0] move_cmd,
  output logic [2:0] held_key,
  output logic       gravity_overrun,
  output logic [1:0] dec_state_o
);

  localparam logic [2:0] CMD_NONE    = 3'd0;
  localparam logic [2:0] CMD_LEFT    = 3'd1;
  localparam logic [2:0] CMD_RIGHT   = 3'd2;
  localparam logic [2:0] CMD_DOWN    = 3'd3;
  localparam logic [2:0] CMD_ROTATE  = 3'd4;
  localparam logic [2:0] CMD_GRAVITY = 3'd5;

  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_BRK     = 2'd1,
    D_EXT     = 2'd2,
    D_EXT_BRK = 2'd3
  } dec_state_e;

  dec_state_e dec_q, dec_d;

  logic             make_vld;
  logic             brk_vld;
  logic             code_ext;
  logic [2:0]       dec_cmd;

  logic             req_q, req_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [2:0]       held_q, held_d;
  logic             grav_q, grav_d;
  logic [2:0]       key_q, key_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             issue_grav;
  logic             issue_key;
  logic             brk_held;

  // Scan code to command; unmapped codes give CMD_NONE.
  function automatic logic [2:0] map_key(input logic ext, input logic [7:0] code);
    logic [2:0] c;
    c = CMD_NONE;
    if (!ext) begin
      case (code)
        8'h1C:   c = CMD_LEFT;
        8'h23:   c = CMD_RIGHT;
        8'h1B:   c = CMD_DOWN;
        8'h1D:   c = CMD_ROTATE;
        default: c = CMD_NONE;
      endcase
    end else begin
      case (code)
        8'h6B:   c = CMD_LEFT;
        8'h74:   c = CMD_RIGHT;
        8'h72:   c = CMD_DOWN;
        8'h75:   c = CMD_ROTATE;
        default: c = CMD_NONE;
      endcase
    end
    return c;
  endfunction

  // Decoder state register; it keeps tracking bytes even while disabled.
  always_ff @(posedge CLOCK_50) begin
    if (reset) dec_q <= D_IDLE;
    else       dec_q <= dec_d;
  end

  // Decoder next state, advancing only on a byte strobe.
  always_comb begin
    dec_d = dec_q;
    if (received_data_en) begin
      case (dec_q)
        D_IDLE: begin
          if (received_data == 8'hF0)      dec_d = D_BRK;
          else if (received_data == 8'hE0) dec_d = D_EXT;
          else                             dec_d = D_IDLE;
        end
        D_BRK:     dec_d = D_IDLE;
        D_EXT:     dec_d = (received_data == 8'hF0) ? D_EXT_BRK : D_IDLE;
        D_EXT_BRK: dec_d = D_IDLE;
        default:   dec_d = D_IDLE;
      endcase
    end
  end

  // Decoder outputs: one-cycle make/break events with the extended flag.
  always_comb begin
    make_vld = 1'b0;
    brk_vld  = 1'b0;
    code_ext = 1'b0;
    if (received_data_en) begin
      case (dec_q)
        D_IDLE:    make_vld = (received_data != 8'hF0) && (received_data != 8'hE0);
        D_BRK:     brk_vld  = 1'b1;
        D_EXT: begin
          make_vld = (received_data != 8'hF0);
          code_ext = 1'b1;
        end
        D_EXT_BRK: begin
          brk_vld  = 1'b1;
          code_ext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dec_cmd = map_key(code_ext, received_data);

  // Key tracking, auto-repeat, gravity capture and command arbitration.
  always_comb begin
    req_d      = req_q;
    cmd_d      = cmd_q;
    held_d     = held_q;
    grav_d     = grav_q;
    key_d      = key_q;
    ovr_d      = ovr_q;
    cnt_d      = cnt_q;
    issue_grav = !req_q && grav_q;
    issue_key  = !req_q && !grav_q && (key_q != CMD_NONE);
    brk_held   = brk_vld && (dec_cmd != CMD_NONE) && (dec_cmd == held_q);

    if (!enable) begin
      // Abort: drop any command in flight and forget pending work.
      req_d  = 1'b0;
      cmd_d  = CMD_NONE;
      held_d = CMD_NONE;
      grav_d = 1'b0;
      key_d  = CMD_NONE;
    end else begin
      // Handshake and issue; issuing clears the pending flag it consumed.
      if (req_q && move_ack) begin
        req_d = 1'b0;
        cmd_d = CMD_NONE;
      end else if (issue_grav) begin
        req_d  = 1'b1;
        cmd_d  = CMD_GRAVITY;
        grav_d = 1'b0;
      end else if (issue_key) begin
        req_d = 1'b1;
        cmd_d = key_q;
        key_d = CMD_NONE;
      end

      // A tick is lost only if the previous one is still waiting and is
      // not being issued on this same edge.
      if (gravity_tick) begin
        if (grav_q && !issue_grav) ovr_d = 1'b1;
        grav_d = 1'b1;
      end

      // Auto-repeat of the held key; a break of that key stops it.
      if ((held_q != CMD_NONE) && !brk_held) begin
        if (cnt_q == '0) begin
          key_d = held_q;
          cnt_d = PERIOD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      if (brk_held) held_d = CMD_NONE;

      // New make of a different key: latest press wins the pending slot.
      if (make_vld && (dec_cmd != CMD_NONE) && (dec_cmd != held_q)) begin
        key_d = dec_cmd;
        if (dec_cmd != CMD_ROTATE) begin
          held_d = dec_cmd;
          cnt_d  = DELAY_LOAD;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      req_q  <= 1'b0;
      cmd_q  <= CMD_NONE;
      held_q <= CMD_NONE;
      grav_q <= 1'b0;
      key_q  <= CMD_NONE;
      ovr_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      req_q  <= req_d;
      cmd_q  <= cmd_d;
      held_q <= held_d;
      grav_q <= grav_d;
      key_q  <= key_d;
      ovr_q  <= ovr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign move_req        = req_q;
  assign move_cmd        = cmd_q;
  assign held_key        = held_q;
  assign gravity_overrun = ovr_q;
  assign dec_state_o     = dec_q;

endmodule

// File: tb/tb_move_request_scheduler.sv
// Directed bench for move_request_scheduler with short repeat timing
// (delay 10, period 4). Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point.
module tb_move_request_scheduler;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       gravity_tick;
  logic       move_ack;
  logic       move_req;
  logic [2:0] move_cmd;
  logic [2:0] held_key;
  logic       gravity_overrun;
  logic [1:0] dec_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  move_request_scheduler #(
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(4),
    .CNT_W        (8)
  ) dut (
    .CLOCK_50        (clk),
    .reset           (reset),
    .enable          (enable),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .gravity_tick    (gravity_tick),
    .move_ack        (move_ack),
    .move_req        (move_req),
    .move_cmd        (move_cmd),
    .held_key        (held_key),
    .gravity_overrun (gravity_overrun),
    .dec_state_o     (dec_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    step();
    received_data_en = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int highs;
    logic prev_req;
    logic [7:0] exp_off;

    reset            = 1'b1;
    enable           = 1'b1;
    received_data    = 8'h00;
    received_data_en = 1'b0;
    gravity_tick     = 1'b0;
    move_ack         = 1'b0;
    step();
    step();
    reset = 1'b0;

    // T1: reset values, single LEFT press and release
    check("rst_req", 32'(move_req), 32'd0);
    check("rst_cmd", 32'(move_cmd), 32'd0);
    check("rst_held", 32'(held_key), 32'd0);
    check("rst_ovr", 32'(gravity_overrun), 32'd0);
    check("rst_dec", 32'(dec_state), 32'd0);
    send_byte(8'h1C);
    check("t1_held_make", 32'(held_key), 32'd1);
    check("t1_req_latency", 32'(move_req), 32'd0);
    send_byte(8'hF0);
    check("t1_req", 32'(move_req), 32'd1);
    check("t1_cmd", 32'(move_cmd), 32'd1);
    check("t1_dec_brk", 32'(dec_state), 32'd1);
    send_byte(8'h1C);
    check("t1_held_brk", 32'(held_key), 32'd0);
    check("t1_req_hold", 32'(move_req), 32'd1);
    check("t1_cmd_hold", 32'(move_cmd), 32'd1);
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
    check("t1_req_ack", 32'(move_req), 32'd0);
    check("t1_cmd_ack", 32'(move_cmd), 32'd0);
    step();
    check("t1_idle", 32'(move_req), 32'd0);

    // T2: hold E0 74; expect RIGHT requests at these edge offsets from the make
    send_byte(8'hE0);
    send_byte(8'h74);
    check("t2_held", 32'(held_key), 32'd2);
    exp_q = {8'd1, 8'd11, 8'd15, 8'd19, 8'd23, 8'd27};
    prev_req = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      received_data_en = (i >= 27 && i <= 29);
      received_data    = (i == 27) ? 8'hE0 : (i == 28) ? 8'hF0 : 8'h74;
      step();
      received_data_en = 1'b0;
      move_ack = move_req;
      if (move_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("t2_extra_req", 32'(i), 32'd0);
        end else begin
          exp_off = exp_q.pop_front();
          check("t2_rise_edge", 32'(i), 32'(exp_off));
          check("t2_rise_cmd", 32'(move_cmd), 32'd2);
        end
      end
      prev_req = move_req;
    end
    move_ack = 1'b0;
    check("t2_missing", 32'(exp_q.size()), 32'd0);
    check("t2_held_end", 32'(held_key), 32'd0);

    // T3: gravity and ROTATE together; gravity first, rotate after gap, no repeat
    gravity_tick = 1'b1;
    send_byte(8'h1D);
    gravity_tick = 1'b0;
    check("t3_rot_not_held", 32'(held_key), 32'd0);
    step();
    check("t3_grav_req", 32'(move_req), 32'd1);
    check("t3_grav_cmd", 32'(move_cmd), 32'd5);
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
    check("t3_gap", 32'(move_req), 32'd0);
    step();
    check("t3_rot_req", 32'(move_req), 32'd1);
    check("t3_rot_cmd", 32'(move_cmd), 32'd4);
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (move_req) highs++;
    end
    check("t3_no_repeat", 32'(highs), 32'd0);

    // T4: blocked request, overrun on second waiting tick, last key wins
    gravity_tick = 1'b1;
    step();
    gravity_tick = 1'b0;
    step();
    check("t4_busy_cmd", 32'(move_cmd), 32'd5);
    gravity_tick = 1'b1;
    step();
    check("t4_ovr_first", 32'(gravity_overrun), 32'd0);
    step();
    gravity_tick = 1'b0;
    check("t4_ovr_second", 32'(gravity_overrun), 32'd1);
    send_byte(8'h1C);
    send_byte(8'h23);
    check("t4_held_right", 32'(held_key), 32'd2);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("t4_brk_other", 32'(held_key), 32'd2);
    send_byte(8'hF0);
    send_byte(8'h23);
    check("t4_held_clr", 32'(held_key), 32'd0);
    check("t4_still_req", 32'(move_req), 32'd1);
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
    step();
    check("t4_grav2_cmd", 32'(move_cmd), 32'd5);
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
    step();
    check("t4_key_req", 32'(move_req), 32'd1);
    check("t4_key_cmd", 32'(move_cmd), 32'd2);
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (move_req) highs++;
    end
    check("t4_no_more", 32'(highs), 32'd0);
    check("t4_ovr_sticky", 32'(gravity_overrun), 32'd1);

    // T5: tick on the ack edge of a GRAVITY
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_ovr_rst", 32'(gravity_overrun), 32'd0);
    gravity_tick = 1'b1;
    step();
    gravity_tick = 1'b0;
    step();
    check("t5_first_cmd", 32'(move_cmd), 32'd5);
    move_ack     = 1'b1;
    gravity_tick = 1'b1;
    step();
    move_ack     = 1'b0;
    gravity_tick = 1'b0;
    check("t5_gap", 32'(move_req), 32'd0);
    check("t5_ovr_ack", 32'(gravity_overrun), 32'd0);
    step();
    check("t5_second_req", 32'(move_req), 32'd1);
    check("t5_second_cmd", 32'(move_cmd), 32'd5);
    check("t5_ovr_end", 32'(gravity_overrun), 32'd0);
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;

    // T6: disable aborts, decoder keeps tracking, reset mid-request
    gravity_tick = 1'b1;
    step();
    gravity_tick = 1'b0;
    step();
    send_byte(8'h1C);
    check("t6_held", 32'(held_key), 32'd1);
    enable = 1'b0;
    step();
    check("t6_dis_req", 32'(move_req), 32'd0);
    check("t6_dis_cmd", 32'(move_cmd), 32'd0);
    check("t6_dis_held", 32'(held_key), 32'd0);
    send_byte(8'hE0);
    check("t6_dec_track", 32'(dec_state), 32'd2);
    gravity_tick = 1'b1;
    step();
    gravity_tick = 1'b0;
    enable = 1'b1;
    step();
    step();
    check("t6_nothing_pend", 32'(move_req), 32'd0);
    send_byte(8'h74);
    check("t6_ext_make", 32'(held_key), 32'd2);
    step();
    check("t6_req_cmd", 32'(move_cmd), 32'd2);
    reset    = 1'b1;
    move_ack = 1'b1;
    step();
    reset    = 1'b0;
    move_ack = 1'b0;
    check("t6_rst_req", 32'(move_req), 32'd0);
    check("t6_rst_cmd", 32'(move_cmd), 32'd0);
    check("t6_rst_held", 32'(held_key), 32'd0);
    check("t6_rst_ovr", 32'(gravity_overrun), 32'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
